i2c_slave_eeprom: RTL and testbench

I2C target (responder) that emulates a 256-byte AT24C02-style EEPROM on the board's two-wire bus. It is the far end of the team's I2C master: it decodes START/STOP, matches its 7-bit device address, accepts word-address and data bytes, and returns stored bytes on reads. It runs on the 50 MHz system clock and oversamples the 100 kHz bus. Byte 0x00 is exported for on-board display and debug.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_bus_sync.sv | 48 ++++
 rtl/i2c_slave_eeprom.sv | 179 +++++++++++++++++
 tb/tb_i2c_slave_eeprom.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, AT24C02 defaults and a
// page-limited pointer increment used by EEPROM-style write pointers.
package i2c_pkg;

  localparam logic [6:0] AT24C02_ADDR = 7'h50;
  localparam int         MEM_DEPTH    = 256;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEV      = 4'd1,
    ST_DEV_ACK  = 4'd2,
    ST_WADR     = 4'd3,
    ST_WADR_ACK = 4'd4,
    ST_WR       = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD       = 4'd7,
    ST_RD_ACK   = 4'd8
  } state_t;

  // Increment only the bits under mask; bits above it stay put (page wrap).
  function automatic logic [7:0] page_inc(input logic [7:0] ptr, input logic [7:0] mask);
    return (ptr & ~mask) | ((ptr + 8'd1) & mask);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-wire bus front end: 2-FF synchronizers on scl/sda, a one-cycle history
// stage, and combinational START/STOP/scl edge pulses. Pulses are suppressed
// until the pipeline has been refilled with real pin values after reset, so
// the reset value of the flops can never fake a bus condition.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_val,
  output logic start,
  output logic stop,
  output logic scl_rise,
  output logic scl_fall
);

  // bit 1 = scl, bit 0 = sda
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic [1:0] hist_reg;
  logic [1:0] fill_cnt_reg;
  logic       armed;

  // Synchronize both lines and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg     <= 2'b11;
      sync_reg     <= 2'b11;
      hist_reg     <= 2'b11;
      fill_cnt_reg <= 2'd0;
    end else begin
      meta_reg <= {scl, sda};
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
      if (fill_cnt_reg != 2'd3) begin
        fill_cnt_reg <= fill_cnt_reg + 2'd1;
      end
    end
  end

  assign armed    = (fill_cnt_reg == 2'd3);
  assign sda_val  = sync_reg[0];
  assign scl_rise = armed &  sync_reg[1] & ~hist_reg[1];
  assign scl_fall = armed & ~sync_reg[1] &  hist_reg[1];
  assign start    = armed & sync_reg[1] & hist_reg[1] & ~sync_reg[0] &  hist_reg[0];
  assign stop     = armed & sync_reg[1] & hist_reg[1] &  sync_reg[0] & ~hist_reg[0];

endmodule

// File: rtl/i2c_slave_eeprom.sv
// I2C target emulating a 256-byte AT24C02-style EEPROM. Bits are sampled on
// scl rise, sda drive changes only on scl fall, writes commit on the 8th
// data-bit rise and byte 0x00 is exported for display.
module i2c_slave_eeprom
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = AT24C02_ADDR,
  parameter int         PAGE_BYTES = 8
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] at24c02_00_data,
  output logic       busy,
  output logic [7:0] addr_ptr
);

  localparam logic [7:0] PAGE_MASK = 8'(PAGE_BYTES - 1);

  logic       sda_val;
  logic       start;
  logic       stop;
  logic       scl_rise;
  logic       scl_fall;

  state_t     state_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] ptr_reg;
  logic       sda_oe_reg;
  logic [7:0] mem [MEM_DEPTH];
  logic       mem_we;
  logic [7:0] mem_wdata;

  i2c_bus_sync u_sync (
    .clk      (sys_clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .sda_val  (sda_val),
    .start    (start),
    .stop     (stop),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall)
  );

  // Open-drain: pull low or release.
  assign sda = sda_oe_reg ? 1'b0 : 1'bz;

  // A data byte is complete on the 8th scl rise while in WR.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = {shift_reg[6:0], sda_val};
    if (state_reg == ST_WR && scl_rise && bit_cnt_reg == 4'd7) begin
      mem_we = 1'b1;
    end
  end

  // Bus protocol FSM: bit shifting, ACK generation, read drive, pointer.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'h00;
      ptr_reg     <= 8'h00;
      sda_oe_reg  <= 1'b0;
    end else if (stop) begin
      state_reg  <= ST_IDLE;
      sda_oe_reg <= 1'b0;
    end else if (start) begin
      state_reg   <= ST_DEV;
      bit_cnt_reg <= 4'd0;
      sda_oe_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_DEV, ST_WADR, ST_WR: begin
          if (scl_rise && bit_cnt_reg != 4'd8) begin
            shift_reg   <= {shift_reg[6:0], sda_val};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7 && state_reg == ST_WADR) begin
              ptr_reg <= {shift_reg[6:0], sda_val};
            end
            if (bit_cnt_reg == 4'd7 && state_reg == ST_WR) begin
              ptr_reg <= page_inc(ptr_reg, PAGE_MASK);
            end
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            bit_cnt_reg <= 4'd0;
            if (state_reg == ST_DEV) begin
              if (shift_reg[7:1] == DEV_ADDR) begin
                state_reg  <= ST_DEV_ACK;
                sda_oe_reg <= 1'b1;
              end else begin
                state_reg <= ST_IDLE;
              end
            end else begin
              state_reg  <= (state_reg == ST_WADR) ? ST_WADR_ACK : ST_WR_ACK;
              sda_oe_reg <= 1'b1;
            end
          end
        end
        ST_DEV_ACK: begin
          // shift_reg[0] still holds the R/W bit during the ACK slot
          if (scl_fall) begin
            if (shift_reg[0]) begin
              state_reg  <= ST_RD;
              shift_reg  <= mem[ptr_reg];
              sda_oe_reg <= ~mem[ptr_reg][7];
            end else begin
              state_reg  <= ST_WADR;
              sda_oe_reg <= 1'b0;
            end
          end
        end
        ST_WADR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            state_reg  <= ST_WR;
            sda_oe_reg <= 1'b0;
          end
        end
        ST_RD: begin
          if (scl_rise) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              state_reg   <= ST_RD_ACK;
              bit_cnt_reg <= 4'd0;
              sda_oe_reg  <= 1'b0;
            end else begin
              shift_reg  <= {shift_reg[6:0], 1'b0};
              sda_oe_reg <= ~shift_reg[6];
            end
          end
        end
        ST_RD_ACK: begin
          // Master ACK advances the pointer; NACK ends the read.
          if (scl_rise) begin
            if (sda_val) begin
              state_reg <= ST_IDLE;
            end else begin
              ptr_reg <= ptr_reg + 8'd1;
            end
          end else if (scl_fall) begin
            state_reg  <= ST_RD;
            shift_reg  <= mem[ptr_reg];
            sda_oe_reg <= ~mem[ptr_reg][7];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Storage: one reset-cleared byte register per address.
  genvar gi;
  for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_mem
    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        mem[gi] <= 8'h00;
      end else if (mem_we && ptr_reg == 8'(gi)) begin
        mem[gi] <= mem_wdata;
      end
    end
  end

  // Registered copy of byte 0x00 for the display path.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      at24c02_00_data <= 8'h00;
    end else begin
      at24c02_00_data <= mem[0];
    end
  end

  assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_DEV);
  assign addr_ptr = ptr_reg;

endmodule

// File: tb/tb_i2c_slave_eeprom.sv
// Bench for i2c_slave_eeprom: bit-banged I2C master, scoreboard queue of
// expected ACK bits and read bytes, one task per scenario.
module tb_i2c_slave_eeprom;

  localparam int Q = 10;  // quarter scl period in sys_clk cycles

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda_low;
  wire        sda;
  logic [7:0] at24c02_00_data;
  logic       busy;
  logic [7:0] addr_ptr;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];

  pullup pu_sda (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #10 sys_clk = ~sys_clk;

  i2c_slave_eeprom dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .scl             (scl),
    .sda             (sda),
    .at24c02_00_data (at24c02_00_data),
    .busy            (busy),
    .addr_ptr        (addr_ptr)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; tick(Q);
    scl = 1'b1;       tick(Q);
    m_sda_low = 1'b1; tick(Q);
    scl = 1'b0;       tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; tick(Q);
    scl = 1'b1;       tick(Q);
    m_sda_low = 1'b0; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; tick(Q);
    scl = 1'b1;     tick(2 * Q);
    scl = 1'b0;     tick(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; tick(Q);
    scl = 1'b1;       tick(Q);
    b = sda;          tick(Q);
    scl = 1'b0;       tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
    $display("[TB] wr byte %02h ack=%b", d, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
    $display("[TB] rd byte %02h master_ack=%b", d, nack);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0;
    tick(3);
    tests_run++;
    if (at24c02_00_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %02h expected 00", at24c02_00_data); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (addr_ptr !== 8'h00) begin tests_failed++; $display("FAIL reset_ptr: got %02h expected 00", addr_ptr); end
    tests_run++;
    if (sda !== 1'b1) begin tests_failed++; $display("FAIL reset_sda: got %b expected 1", sda); end
    rst = 1'b0;
    tick(5);
    $display("[TB] reset released");
  endtask

  task automatic test_write_basic();
    logic [7:0] seq[3] = '{8'hA0, 8'h00, 8'h5A};
    logic ack;
    logic [7:0] e;
    i2c_start();
    foreach (seq[i]) begin
      exp_q.push_back(8'h00);
      write_byte(seq[i], ack);
      e = exp_q.pop_front();
      tests_run++;
      if (ack !== e[0]) begin tests_failed++; $display("FAIL basic_ack%0d: got %b expected %b", i, ack, e[0]); end
    end
    i2c_stop();
    tick(5);
    tests_run++;
    if (at24c02_00_data !== 8'h5A) begin tests_failed++; $display("FAIL basic_data00: got %02h expected 5a", at24c02_00_data); end
    tests_run++;
    if (addr_ptr !== 8'h01) begin tests_failed++; $display("FAIL basic_ptr: got %02h expected 01", addr_ptr); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_random_read();
    logic [7:0] seq[3] = '{8'hA0, 8'h10, 8'h33};
    logic ack;
    logic [7:0] d;
    logic [7:0] e;
    i2c_start();
    foreach (seq[i]) begin
      exp_q.push_back(8'h00);
      write_byte(seq[i], ack);
      e = exp_q.pop_front();
      tests_run++;
      if (ack !== e[0]) begin tests_failed++; $display("FAIL rr_load_ack%0d: got %b expected %b", i, ack, e[0]); end
    end
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    i2c_start();
    exp_q.push_back(8'h00);
    write_byte(8'hA1, ack);
    e = exp_q.pop_front();
    tests_run++;
    if (ack !== e[0]) begin tests_failed++; $display("FAIL rr_addr_ack: got %b expected %b", ack, e[0]); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL rr_busy_during: got %b expected 1", busy); end
    exp_q.push_back(8'h33);
    read_byte(1'b1, d);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL rr_data: got %02h expected %02h", d, e); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rr_busy_after_nack: got %b expected 0", busy); end
    i2c_stop();
  endtask

  task automatic test_page_wrap();
    logic [7:0] seq[5] = '{8'hA0, 8'h06, 8'h11, 8'h22, 8'h33};
    logic ack;
    logic [7:0] d;
    logic [7:0] e;
    i2c_start();
    foreach (seq[i]) begin
      exp_q.push_back(8'h00);
      write_byte(seq[i], ack);
      e = exp_q.pop_front();
      tests_run++;
      if (ack !== e[0]) begin tests_failed++; $display("FAIL pw_ack%0d: got %b expected %b", i, ack, e[0]); end
    end
    i2c_stop();
    tick(5);
    tests_run++;
    if (addr_ptr !== 8'h01) begin tests_failed++; $display("FAIL pw_ptr: got %02h expected 01", addr_ptr); end
    tests_run++;
    if (at24c02_00_data !== 8'h33) begin tests_failed++; $display("FAIL pw_data00: got %02h expected 33", at24c02_00_data); end
    // Read back 0x06..0x08: reads do not page-wrap, 0x08 was never written.
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h06, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      read_byte((i == 2), d);
      e = exp_q.pop_front();
      tests_run++;
      if (d !== e) begin tests_failed++; $display("FAIL pw_read%0d: got %02h expected %02h", i, d, e); end
    end
    i2c_stop();
  endtask

  task automatic test_seq_read_wrap();
    logic [7:0] seq[4] = '{8'hA0, 8'hFE, 8'hC1, 8'h7E};
    logic ack;
    logic [7:0] d;
    logic [7:0] e;
    i2c_start();
    foreach (seq[i]) write_byte(seq[i], ack);
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFE, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    exp_q.push_back(8'hC1); exp_q.push_back(8'h7E); exp_q.push_back(8'h33);
    for (int i = 0; i < 3; i++) begin
      read_byte((i == 2), d);
      e = exp_q.pop_front();
      tests_run++;
      if (d !== e) begin tests_failed++; $display("FAIL sr_read%0d: got %02h expected %02h", i, d, e); end
    end
    i2c_stop();
    tests_run++;
    if (addr_ptr !== 8'h00) begin tests_failed++; $display("FAIL sr_ptr: got %02h expected 00", addr_ptr); end
  endtask

  task automatic test_wrong_addr();
    logic [7:0] seq[3] = '{8'hA2, 8'h00, 8'h99};
    logic ack;
    logic [7:0] e;
    i2c_start();
    foreach (seq[i]) begin
      exp_q.push_back(8'h01);
      write_byte(seq[i], ack);
      e = exp_q.pop_front();
      tests_run++;
      if (ack !== e[0]) begin tests_failed++; $display("FAIL wa_ack%0d: got %b expected %b", i, ack, e[0]); end
    end
    i2c_stop();
    tick(5);
    tests_run++;
    if (at24c02_00_data !== 8'h33) begin tests_failed++; $display("FAIL wa_data00: got %02h expected 33", at24c02_00_data); end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] seq[3] = '{8'hA0, 8'h00, 8'hC3};
    // mem[0x00]=0x33 and ptr=0x00, so the first read bit is a driven 0
    i2c_start();
    write_byte(8'hA1, ack);
    tests_run++;
    if (sda !== 1'b0) begin tests_failed++; $display("FAIL rm_drive0: got %b expected 0", sda); end
    rst = 1'b1;
    #2;
    tests_run++;
    if (sda !== 1'b1) begin tests_failed++; $display("FAIL rm_release: got %b expected 1", sda); end
    tick(1);
    rst = 1'b0;
    tick(2);
    tests_run++;
    if (at24c02_00_data !== 8'h00) begin tests_failed++; $display("FAIL rm_data00: got %02h expected 00", at24c02_00_data); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rm_busy: got %b expected 0", busy); end
    tests_run++;
    if (addr_ptr !== 8'h00) begin tests_failed++; $display("FAIL rm_ptr: got %02h expected 00", addr_ptr); end
    // Rest of the interrupted read: the target must stay silent.
    exp_q.push_back(8'hFF);
    read_byte(1'b1, d);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL rm_silent: got %02h expected %02h", d, e); end
    i2c_stop();
    // Fresh transaction after reset.
    i2c_start();
    foreach (seq[i]) begin
      exp_q.push_back(8'h00);
      write_byte(seq[i], ack);
      e = exp_q.pop_front();
      tests_run++;
      if (ack !== e[0]) begin tests_failed++; $display("FAIL rm_ack%0d: got %b expected %b", i, ack, e[0]); end
    end
    i2c_stop();
    tick(5);
    tests_run++;
    if (at24c02_00_data !== 8'hC3) begin tests_failed++; $display("FAIL rm_new_data00: got %02h expected c3", at24c02_00_data); end
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    exp_q.push_back(8'hC3);
    read_byte(1'b1, d);
    e = exp_q.pop_front();
    tests_run++;
    if (d !== e) begin tests_failed++; $display("FAIL rm_readback: got %02h expected %02h", d, e); end
    i2c_stop();
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_random_read();
    test_page_wrap();
    test_seq_read_wrap();
    test_wrong_addr();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
